am_class_trainer: RTL and testbench

- Training-side writer for the associative memory: builds one class prototype hypervector from a stream of labelled training hypervectors.
- Bundles samples with per-bit counters, then thresholds them by majority.
- Presents {prototype, label, sample count} on a valid/ready output, to be loaded into the AM class storage (AM_A/AM_V content).
- Sits between the encoder output and AM prototype storage; one instance per modality.

---
 rtl/am_class_trainer.sv | 183 ++++++++++++++++++
 tb/tb_am_class_trainer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_class_trainer.sv
// am_class_trainer
//   Training-side writer for the associative memory. It bundles a stream of
//   labelled training hypervectors into one class prototype: every bit gets a
//   population counter, and when the last sample of the class arrives the
//   counters are thresholded by majority. The prototype is then presented,
//   together with its label and sample count, on a valid/ready output so it
//   can be loaded into the AM class storage.
//
// Ports
//   Clk_CI             rising-edge clock
//   Reset_RBI          asynchronous active-low reset
//   ValidIn_SI         upstream sample valid
//   ReadyOut_SO        block can accept a sample (IDLE / ACCUMULATE)
//   HypervectorIn_DI   training hypervector
//   LabelIn_DI         class label, latched from the first sample only
//   LastIn_SI          marks the final sample of the class
//   ValidOut_SO        prototype valid
//   ReadyIn_SI         downstream accepts the prototype
//   PrototypeOut_DO    majority-bundled prototype
//   LabelOut_DO        label of the class
//   SampleCountOut_DO  number of samples bundled into the prototype
//   Overflow_SO        at least one sample of the class was dropped because
//                      the sample counter was saturated (sticky per class)

module am_class_trainer #(
  parameter int HV_DIMENSION = 2000,
  parameter int LABEL_WIDTH  = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RBI,
  input  logic                     ValidIn_SI,
  output logic                     ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1]  HypervectorIn_DI,
  input  logic [LABEL_WIDTH-1:0]   LabelIn_DI,
  input  logic                     LastIn_SI,
  output logic                     ValidOut_SO,
  input  logic                     ReadyIn_SI,
  output logic [0:HV_DIMENSION-1]  PrototypeOut_DO,
  output logic [LABEL_WIDTH-1:0]   LabelOut_DO,
  output logic [CNT_WIDTH-1:0]     SampleCountOut_DO,
  output logic                     Overflow_SO
);

  // Largest sample count representable; further samples are discarded.
  localparam logic [CNT_WIDTH-1:0] MaxCount = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    Idle,
    Accumulate,
    Threshold,
    OutputStable
  } state_t;

  state_t                   state;
  logic [CNT_WIDTH-1:0]     bitCnt [HV_DIMENSION];
  logic [CNT_WIDTH-1:0]     sampleCnt;
  logic [0:HV_DIMENSION-1]  firstSample;
  logic [LABEL_WIDTH-1:0]   labelReg;
  logic [0:HV_DIMENSION-1]  thresholded;
  logic                     accept;
  logic                     emit;
  logic                     countRoom;

  assign accept    = ValidIn_SI & ReadyOut_SO;
  assign emit      = ValidOut_SO & ReadyIn_SI;
  assign countRoom = (sampleCnt < MaxCount);

  // Majority decision for one bit. Both sides are widened by one bit so that
  // 2*ones cannot wrap; an exact tie falls back to the first sample's bit.
  function automatic logic majorityBit(input logic [CNT_WIDTH-1:0] ones,
                                       input logic [CNT_WIDTH-1:0] total,
                                       input logic                 tieBit);
    logic [CNT_WIDTH:0] twiceOnes;
    logic [CNT_WIDTH:0] totalExt;
    twiceOnes = {ones, 1'b0};
    totalExt  = {1'b0, total};
    if (twiceOnes > totalExt)
      return 1'b1;
    else if (twiceOnes < totalExt)
      return 1'b0;
    else
      return tieBit;
  endfunction

  always_comb begin
    thresholded = '0;
    for (int i = 0; i < HV_DIMENSION; i++)
      thresholded[i] = majorityBit(bitCnt[i], sampleCnt, firstSample[i]);
  end

  // Per-bit population counters. A sample arriving while the sample counter
  // is saturated is consumed but leaves the counters untouched, which keeps
  // every bitCnt[i] <= sampleCnt and therefore free of wrap-around.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      for (int i = 0; i < HV_DIMENSION; i++)
        bitCnt[i] <= '0;
    end else if (accept && (state == Idle)) begin
      for (int i = 0; i < HV_DIMENSION; i++)
        bitCnt[i] <= CNT_WIDTH'(HypervectorIn_DI[i]);
    end else if (accept && (state == Accumulate) && countRoom) begin
      for (int i = 0; i < HV_DIMENSION; i++)
        bitCnt[i] <= bitCnt[i] + CNT_WIDTH'(HypervectorIn_DI[i]);
    end else if ((state == OutputStable) && emit) begin
      for (int i = 0; i < HV_DIMENSION; i++)
        bitCnt[i] <= '0;
    end
  end

  // Control FSM with registered handshake outputs. The output registers are
  // written only on the THRESHOLD step, so the last prototype stays visible
  // after it has been taken until the next class replaces it.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state             <= Idle;
      sampleCnt         <= '0;
      firstSample       <= '0;
      labelReg          <= '0;
      Overflow_SO       <= 1'b0;
      ReadyOut_SO       <= 1'b1;
      ValidOut_SO       <= 1'b0;
      PrototypeOut_DO   <= '0;
      LabelOut_DO       <= '0;
      SampleCountOut_DO <= '0;
    end else begin
      case (state)
        Idle: begin
          if (accept) begin
            sampleCnt   <= CNT_WIDTH'(1);
            labelReg    <= LabelIn_DI;
            firstSample <= HypervectorIn_DI;
            Overflow_SO <= 1'b0;
            if (LastIn_SI) begin
              state       <= Threshold;
              ReadyOut_SO <= 1'b0;
            end else begin
              state <= Accumulate;
            end
          end
        end

        Accumulate: begin
          if (accept) begin
            if (countRoom)
              sampleCnt <= sampleCnt + CNT_WIDTH'(1);
            else
              Overflow_SO <= 1'b1;
            if (LastIn_SI) begin
              state       <= Threshold;
              ReadyOut_SO <= 1'b0;
            end
          end
        end

        // Stage boundary: counters -> majority threshold -> output registers
        Threshold: begin
          PrototypeOut_DO   <= thresholded;
          LabelOut_DO       <= labelReg;
          SampleCountOut_DO <= sampleCnt;
          ValidOut_SO       <= 1'b1;
          state             <= OutputStable;
        end

        OutputStable: begin
          if (emit) begin
            ValidOut_SO <= 1'b0;
            ReadyOut_SO <= 1'b1;
            sampleCnt   <= '0;
            state       <= Idle;
          end
        end

        default: begin
          state       <= Idle;
          ReadyOut_SO <= 1'b1;
          ValidOut_SO <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am_class_trainer.sv
// Bench for am_class_trainer. Two instances share one stimulus stream: one
// with 8-bit counters and one with 2-bit counters (saturates after 3
// samples). A behavioural model keeps the raw samples of the current class
// in a queue and derives prototype, count and overflow from them; a compare
// process checks both instances against it on every cycle. Directed classes
// add literal expectations; the rest is randomized.

module tb_am_class_trainer;

  localparam int HV  = 8;
  localparam int LW  = 2;
  localparam int CW  = 8;
  localparam int CW2 = 2;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          validIn = 1'b0;
  logic          lastIn = 1'b0;
  logic          readyIn = 1'b0;
  logic [0:HV-1] hvIn = '0;
  logic [LW-1:0] labelIn = '0;

  logic          readyOut, validOut, ovf;
  logic [0:HV-1] protoOut;
  logic [LW-1:0] labelOut;
  logic [CW-1:0] countOut;
  logic           readyOut2, validOut2, ovf2;
  logic [0:HV-1]  protoOut2;
  logic [LW-1:0]  labelOut2;
  logic [CW2-1:0] countOut2;

  bit randReady = 1'b0;
  bit forceReady = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am_class_trainer #(.HV_DIMENSION(HV), .LABEL_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .Clk_CI(clk), .Reset_RBI(rstN), .ValidIn_SI(validIn), .ReadyOut_SO(readyOut),
    .HypervectorIn_DI(hvIn), .LabelIn_DI(labelIn), .LastIn_SI(lastIn),
    .ValidOut_SO(validOut), .ReadyIn_SI(readyIn), .PrototypeOut_DO(protoOut),
    .LabelOut_DO(labelOut), .SampleCountOut_DO(countOut), .Overflow_SO(ovf));

  am_class_trainer #(.HV_DIMENSION(HV), .LABEL_WIDTH(LW), .CNT_WIDTH(CW2)) dutSat (
    .Clk_CI(clk), .Reset_RBI(rstN), .ValidIn_SI(validIn), .ReadyOut_SO(readyOut2),
    .HypervectorIn_DI(hvIn), .LabelIn_DI(labelIn), .LastIn_SI(lastIn),
    .ValidOut_SO(validOut2), .ReadyIn_SI(readyIn), .PrototypeOut_DO(protoOut2),
    .LabelOut_DO(labelOut2), .SampleCountOut_DO(countOut2), .Overflow_SO(ovf2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0: taking samples, 1: the one computing cycle, 2: presenting
  int            phase;
  bit            inClass;
  logic [0:HV-1] q[$];
  logic [LW-1:0] lblLatched, lblExp;
  logic [0:HV-1] protoExp [2];
  int            cntExp [2];
  int            limit [2] = '{255, 3};

  function automatic logic [0:HV-1] bundle(input int lim);
    logic [0:HV-1] r;
    int n, ones;
    r = '0;
    n = (q.size() < lim) ? q.size() : lim;
    for (int b = 0; b < HV; b++) begin
      ones = 0;
      for (int s = 0; s < n; s++) ones += int'(q[s][b]);
      if (2 * ones > n)      r[b] = 1'b1;
      else if (2 * ones < n) r[b] = 1'b0;
      else                   r[b] = q[0][b];
    end
    return r;
  endfunction

  task automatic modelReset();
    phase = 0; inClass = 0; q.delete();
    lblLatched = '0; lblExp = '0;
    for (int k = 0; k < 2; k++) begin protoExp[k] = '0; cntExp[k] = 0; end
  endtask

  task automatic modelStep();
    case (phase)
      0: if (validIn) begin
        if (!inClass) begin q.delete(); lblLatched = labelIn; inClass = 1; end
        q.push_back(hvIn);
        if (lastIn) phase = 1;
      end
      1: begin
        for (int k = 0; k < 2; k++) begin
          protoExp[k] = bundle(limit[k]);
          cntExp[k]   = (q.size() < limit[k]) ? q.size() : limit[k];
        end
        lblExp = lblLatched;
        phase = 2;
      end
      default: if (readyIn) begin phase = 0; inClass = 0; end
    endcase
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk);
      if (rstN) modelStep();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("ready",  32'(readyOut),  32'(phase == 0));
      chk("valid",  32'(validOut),  32'(phase == 2));
      chk("proto",  32'(protoOut),  32'(protoExp[0]));
      chk("label",  32'(labelOut),  32'(lblExp));
      chk("count",  32'(countOut),  32'(cntExp[0]));
      chk("ovf",    32'(ovf),       32'(q.size() > limit[0]));
      chk("ready2", 32'(readyOut2), 32'(phase == 0));
      chk("valid2", 32'(validOut2), 32'(phase == 2));
      chk("proto2", 32'(protoOut2), 32'(protoExp[1]));
      chk("label2", 32'(labelOut2), 32'(lblExp));
      chk("count2", 32'(countOut2), 32'(cntExp[1]));
      chk("ovf2",   32'(ovf2),      32'(q.size() > limit[1]));
    end
  end

  // ReadyIn driver: random backpressure or directed level.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      readyIn = randReady ? 1'($urandom_range(0, 1)) : forceReady;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sendSample(input logic [0:HV-1] hv, input logic [LW-1:0] lbl, input logic last);
    bit acc;
    @(negedge clk);
    validIn = 1'b1; hvIn = hv; labelIn = lbl; lastIn = last;
    for (int w = 0; ; w++) begin
      acc = readyOut;
      @(posedge clk);
      if (acc) break;
      if (w >= 200) begin
        chk("accept_timeout", 32'(readyOut), 1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    validIn = 1'b0; hvIn = HV'($urandom); labelIn = LW'($urandom); lastIn = 1'($urandom);
  endtask

  task automatic waitOut(input string tag);
    int w = 0;
    @(negedge clk);
    validIn = 1'b0; lastIn = 1'b0;
    while (!validOut && w < 50) begin @(negedge clk); w++; end
    if (!validOut) chk({tag, "_valid_timeout"}, 32'(validOut), 1);
    #1;
  endtask

  task automatic releaseOut();
    forceReady = 1'b1;
    @(negedge clk);
    forceReady = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1 rstN = 1'b0;
    #2;
    chk("rst_valid", 32'(validOut), 0);
    chk("rst_ready", 32'(readyOut), 1);
    chk("rst_proto", 32'(protoOut), 0);
    chk("rst_count", 32'(countOut), 0);
    chk("rst_ovf",   32'(ovf), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Single sample: valid appears after the second edge.
    sendSample('hB2, 2'd2, 1'b1);
    @(negedge clk); validIn = 1'b0; lastIn = 1'b0; #1;
    chk("t1_lat_vld0", 32'(validOut), 0);
    @(negedge clk); #1;
    chk("t1_lat_vld1", 32'(validOut), 1);
    chk("t1_proto", 32'(protoOut), 'hB2);
    chk("t1_label", 32'(labelOut), 2);
    chk("t1_count", 32'(countOut), 1);
    chk("t1_ovf",   32'(ovf), 0);
    releaseOut();

    // Three samples, later labels differ from the first.
    sendSample('hC0, 2'd1, 1'b0);
    sendSample('hA0, 2'd3, 1'b0);
    sendSample('h61, 2'd0, 1'b1);
    waitOut("t2");
    chk("t2_proto", 32'(protoOut), 'hE0);
    chk("t2_model", 32'(protoExp[0]), 'hE0);
    chk("t2_label", 32'(labelOut), 1);
    chk("t2_count", 32'(countOut), 3);

    releaseOut();
    // Two samples with ties resolved from the first sample.
    sendSample('hF0, 2'd3, 1'b0);
    sendSample('h3C, 2'd3, 1'b1);
    waitOut("t3");
    chk("t3_proto", 32'(protoOut), 'hF0);
    chk("t3_model", 32'(protoExp[0]), 'hF0);
    chk("t3_count", 32'(countOut), 2);

    // Backpressure: output held, pending sample refused until emit.
    fork
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk); #1;
          chk("bp_valid", 32'(validOut), 1);
          chk("bp_ready", 32'(readyOut), 0);
          chk("bp_proto", 32'(protoOut), 'hF0);
        end
        forceReady = 1'b1;
      end
      sendSample('h3C, 2'd1, 1'b1);
    join
    forceReady = 1'b0;
    waitOut("t4");
    chk("t4_proto", 32'(protoOut), 'h3C);
    chk("t4_count", 32'(countOut), 1);
    chk("t4_label", 32'(labelOut), 1);
    releaseOut();

    // Five all-ones samples: the 2-bit instance saturates at 3.
    for (int i = 0; i < 5; i++) sendSample('hFF, 2'd3, 1'(i == 4));
    waitOut("t5");
    chk("t5_proto2", 32'(protoOut2), 'hFF);
    chk("t5_count2", 32'(countOut2), 3);
    chk("t5_ovf2",   32'(ovf2), 1);
    chk("t5_count",  32'(countOut), 5);
    chk("t5_ovf",    32'(ovf), 0);
    releaseOut();
    sendSample('h0F, 2'd0, 1'b1);
    waitOut("t5b");
    chk("t5b_ovf2",   32'(ovf2), 0);
    chk("t5b_count2", 32'(countOut2), 1);
    chk("t5b_proto2", 32'(protoOut2), 'h0F);
    releaseOut();

    // 8-bit saturation: 256 ones then 4 zeros; only the first 255 count.
    for (int i = 0; i < 260; i++) sendSample((i < 256) ? 'hFF : 'h00, 2'd2, 1'(i == 259));
    waitOut("t5c");
    chk("t5c_count", 32'(countOut), 255);
    chk("t5c_proto", 32'(protoOut), 'hFF);
    chk("t5c_ovf",   32'(ovf), 1);
    releaseOut();

    // Asynchronous reset in the middle of a class.
    sendSample('hA5, 2'd1, 1'b0);
    sendSample('h33, 2'd1, 1'b0);
    @(negedge clk);
    validIn = 1'b0;
    #2 rstN = 1'b0;
    modelReset();
    #1;
    chk("t6_rst_valid", 32'(validOut), 0);
    chk("t6_rst_proto", 32'(protoOut), 0);
    chk("t6_rst_count", 32'(countOut), 0);
    chk("t6_rst_ovf",   32'(ovf), 0);
    chk("t6_rst_ready", 32'(readyOut), 1);
    @(negedge clk);
    rstN = 1'b1;
    sendSample('h5A, 2'd0, 1'b1);
    waitOut("t6");
    chk("t6_proto", 32'(protoOut), 'h5A);
    chk("t6_count", 32'(countOut), 1);
    releaseOut();

    // Randomized classes with input gaps and random backpressure.
    randReady = 1'b1;
    for (int c = 0; c < 40; c++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idleCycle();
        sendSample(HV'($urandom), LW'($urandom), 1'(i == n - 1));
      end
    end
    randReady = 1'b0;
    forceReady = 1'b1;
    repeat (10) idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
